// File: rtl/rx_fsrc_ctrl_pkg.sv
// Shared types and defaults for the RX FSRC control sequencer.
package rx_fsrc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN
  } state_e;

  localparam int TRIG_PULSE_WIDTH_DEF = 4;

endpackage

// File: rtl/fsrc_trig_stretch.sv
// Stretches a single-cycle fire strobe into a PULSE_WIDTH-cycle registered pulse.
module fsrc_trig_stretch #(
  parameter int PULSE_WIDTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pulse_i,
  output logic pulse_o
);

  localparam int CW = $clog2(PULSE_WIDTH + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (pulse_i)
      cnt_d = CW'(PULSE_WIDTH);
    else if (cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign pulse_o = (cnt_q != '0);

endmodule

// File: rtl/rx_fsrc_ctrl.sv
// RX FSRC sequencer: aligns to SYSREF after a start, fires ctrl/trigger/accum events per epoch.
// Optional external start source compiled in with RX_FSRC_CTRL_EXT_TRIG_EN.
module rx_fsrc_ctrl
  import rx_fsrc_ctrl_pkg::*;
#(
  parameter int CTRL_WIDTH       = 40,
  parameter int COUNTER_WIDTH    = 4,
  parameter int NUM_TRIG         = 4,
  parameter int TRIG_PULSE_WIDTH = TRIG_PULSE_WIDTH_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              sysref_int,
  input  logic                              reg_start,
`ifdef RX_FSRC_CTRL_EXT_TRIG_EN
  input  logic                              seq_trig_in,
  input  logic                              seq_ext_trig_en,
`endif
  input  logic [CTRL_WIDTH-1:0]             next_ctrl_value,
  input  logic [COUNTER_WIDTH-1:0]          ctrl_change_cnt,
  input  logic [NUM_TRIG*COUNTER_WIDTH-1:0] first_trig_cnt,
  input  logic [COUNTER_WIDTH-1:0]          accum_reset_cnt,
  output logic [CTRL_WIDTH-1:0]             ctrl_out,
  output logic                              ctrl_update,
  output logic [NUM_TRIG-1:0]               trig_out,
  output logic                              rx_accum_reset,
  output logic                              rx_data_valid,
  output logic                              busy,
  output logic                              done
);

  logic start_req;

`ifdef RX_FSRC_CTRL_EXT_TRIG_EN
  logic seq_trig_q, ext_rise_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_trig_q <= 1'b0;
      ext_rise_q <= 1'b0;
    end else begin
      seq_trig_q <= seq_trig_in;
      ext_rise_q <= seq_trig_in & ~seq_trig_q;
    end
  end

  assign start_req = seq_ext_trig_en ? ext_rise_q : reg_start;
`else
  assign start_req = reg_start;
`endif

  state_e                              state_q, state_d;
  logic                                accept;
  logic [CTRL_WIDTH-1:0]               ctrl_sh_q;
  logic [COUNTER_WIDTH-1:0]            cc_sh_q, ac_sh_q, epoch_q;
  logic [NUM_TRIG*COUNTER_WIDTH-1:0]   tc_sh_q;
  logic                                ep_vld_q;
  logic [CTRL_WIDTH-1:0]               ctrl_out_q;
  logic                                ctrl_upd_q, acc_rst_q, dv_q, done_q;
  logic                                ctrl_fire, acc_fire;
  logic [NUM_TRIG-1:0]                 trig_fire;

  // ep_vld_q is only ever set while arming or running, so it alone qualifies an epoch
  assign ctrl_fire = ep_vld_q && (epoch_q == cc_sh_q);
  assign acc_fire  = ep_vld_q && (epoch_q == ac_sh_q);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: if (start_req) begin
        state_d = ST_ARM;
        accept  = 1'b1;
      end
      ST_ARM:  if (sysref_int) state_d = ST_RUN;
      ST_RUN:  if (acc_fire)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ctrl_sh_q  <= '0;
      cc_sh_q    <= '0;
      ac_sh_q    <= '0;
      tc_sh_q    <= '0;
      epoch_q    <= '0;
      ep_vld_q   <= 1'b0;
      ctrl_out_q <= '0;
      ctrl_upd_q <= 1'b0;
      acc_rst_q  <= 1'b0;
      dv_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ep_vld_q <= 1'b0;
      if (accept) begin
        ctrl_sh_q <= next_ctrl_value;
        cc_sh_q   <= ctrl_change_cnt;
        ac_sh_q   <= accum_reset_cnt;
        tc_sh_q   <= first_trig_cnt;
      end
      if (state_q == ST_ARM && sysref_int) begin
        epoch_q  <= '0;
        ep_vld_q <= 1'b1;
      end else if (state_q == ST_RUN && sysref_int) begin
        epoch_q  <= epoch_q + COUNTER_WIDTH'(1);
        ep_vld_q <= 1'b1;
      end
      ctrl_upd_q <= ctrl_fire;
      if (ctrl_fire) ctrl_out_q <= ctrl_sh_q;
      acc_rst_q <= acc_fire;
      done_q    <= acc_fire;
      if (accept)        dv_q <= 1'b0;
      else if (acc_fire) dv_q <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_TRIG; g++) begin : g_trig
    assign trig_fire[g] = ep_vld_q && (epoch_q == tc_sh_q[g*COUNTER_WIDTH +: COUNTER_WIDTH]);

    fsrc_trig_stretch #(
      .PULSE_WIDTH(TRIG_PULSE_WIDTH)
    ) u_stretch (
      .clk    (clk),
      .reset  (reset),
      .pulse_i(trig_fire[g]),
      .pulse_o(trig_out[g])
    );
  end

  assign ctrl_out       = ctrl_out_q;
  assign ctrl_update    = ctrl_upd_q;
  assign rx_accum_reset = acc_rst_q;
  assign rx_data_valid  = dv_q;
  assign done           = done_q;
  // state leaves RUN on the edge that raises done, so done extends busy by that cycle
  assign busy           = (state_q != ST_IDLE) | done_q;

endmodule

// File: doc/rx_fsrc_ctrl.md
# rx_fsrc_ctrl

Sequencer for the RX FSRC path, the receive-side counterpart of the TX FSRC control sequencer. After a start request, it aligns to the next internal SYSREF pulse and counts SYSREF epochs. At programmed epochs it:
- loads a new control word into the RX FSRC,
- pulses per-channel triggers,
- resets the RX accumulators and asserts the data-valid qualifier.

It sits between the AXI FSRC regmap and the RX FSRC datapath, entirely in the `clk` domain.

## Interface
Parameters:
- CTRL_WIDTH, 40, width of FSRC control word
- COUNTER_WIDTH, 4, width of epoch counter and all epoch-compare inputs
- NUM_TRIG, 4, number of trigger outputs
- TRIG_PULSE_WIDTH, 4, trigger output pulse length in clk cycles (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- sysref_int  in  1  internal SYSREF, single-cycle pulse, clk-synchronous
- reg_start  in  1  regmap start, single-cycle pulse
- seq_trig_in  in  1  external sequence trigger, level (only with RX_FSRC_CTRL_EXT_TRIG_EN)
- seq_ext_trig_en  in  1  1 = use seq_trig_in rising edge as start (only with macro)
- next_ctrl_value  in  CTRL_WIDTH  control word to apply; sampled at start acceptance
- ctrl_change_cnt  in  COUNTER_WIDTH  epoch at which ctrl_out is updated
- first_trig_cnt  in  NUM_TRIG×COUNTER_WIDTH  per-trigger epoch
- accum_reset_cnt  in  COUNTER_WIDTH  final epoch; accumulator reset, sequence end
- ctrl_out  out  CTRL_WIDTH  applied control word
- ctrl_update  out  1  one-cycle pulse when ctrl_out changes
- trig_out  out  NUM_TRIG  trigger pulses
- rx_accum_reset  out  1  one-cycle accumulator reset pulse
- rx_data_valid  out  1  level; RX data qualified
- busy  out  1  sequence in progress (ARM or RUN)
- done  out  1  one-cycle pulse at sequence end

## Operation
- Start source:
  - `start_req` = `reg_start`, or the `seq_trig_in` rising edge when the macro is compiled in and `seq_ext_trig_en` = 1.
  - Edge detect uses `seq_trig_in` registered once.
- States:
  - IDLE:
    - `start_req` → ARM.
    - On that transition: latch `next_ctrl_value` and all cnt inputs into shadow registers, and clear `rx_data_valid`.
  - ARM:
    - `sysref_int` → RUN, epoch counter = 0; this sysref is epoch 0.
  - RUN:
    - Each `sysref_int` increments the epoch counter.
    - After the epoch equal to shadow `accum_reset_cnt` is processed → IDLE.
- Epoch events, evaluated once per epoch against the shadow copies:
  - epoch == `ctrl_change_cnt`: `ctrl_out` ← shadow ctrl, `ctrl_update` pulses.
  - epoch == `first_trig_cnt[i]`: `trig_out[i]` high for TRIG_PULSE_WIDTH cycles.
  - epoch == `accum_reset_cnt`: `rx_accum_reset` and `done` pulse; `rx_data_valid` ← 1 and holds until the next start acceptance.
- Events sharing an epoch fire in the same cycle.
- Cnt values > `accum_reset_cnt` never fire.
- Counter never wraps, because the sequence ends at `accum_reset_cnt`.
- `start_req` in ARM/RUN is ignored.
- `start_req` coincident with `sysref_int` in IDLE: start is accepted, and that sysref is not epoch 0.
- Input changes after acceptance do not affect the running sequence.
- Reset mid-sequence: immediate return to IDLE, all outputs to reset values, shadow cleared.

## Timing
- Reset values: `ctrl_out`=0, `ctrl_update`=0, `trig_out`=0, `rx_accum_reset`=0, `rx_data_valid`=0, `busy`=0, `done`=0.
- `busy` = 1 from the cycle after start acceptance through the cycle in which `done` is high.
- Epoch latency: `sysref_int` at cycle t → epoch registered at t+1 → event outputs high at t+2.
- Trigger: `trig_out[i]` high cycles t+2 … t+1+TRIG_PULSE_WIDTH.
- Minimum SYSREF spacing is TRIG_PULSE_WIDTH+2 cycles; closer spacing is unsupported.
- `seq_trig_in` start adds one cycle of latency versus `reg_start`.

## Configuration
- RX_FSRC_CTRL_EXT_TRIG_EN:
  - Defined: `seq_trig_in`/`seq_ext_trig_en` ports exist, with edge detect and source mux.
  - Undefined: ports absent; `reg_start` is the only start source.

## Structure
- `rx_fsrc_ctrl_pkg`: state enum (IDLE, ARM, RUN) and default TRIG_PULSE_WIDTH constant.
- Sub-module `fsrc_trig_stretch`: one-bit pulse → TRIG_PULSE_WIDTH-cycle registered pulse, instantiated NUM_TRIG times.

## Test plan
- Sequence with ctrl_change_cnt=1, first_trig_cnt={2,3,3,5}, accum_reset_cnt=4; reg_start, then sysref every 16 cycles:
  - `ctrl_update` at epoch 1.
  - `trig_out[0]` at epoch 2; `trig_out[2:1]` together at epoch 3; `trig_out[3]` never.
  - `rx_accum_reset`, `done` and `rx_data_valid` rise at epoch 4, each 2 cycles after its sysref.
- All cnts=0: every event fires 2 cycles after the first sysref following start.
- reg_start during RUN and a second start in ARM → ignored; the sequence completes unchanged.
- Change next_ctrl_value after start → `ctrl_out` equals the value latched at start.
- Reset asserted at epoch 2 → all outputs 0 next cycle; a new start runs a full sequence.
- With macro, seq_ext_trig_en=1:
  - `seq_trig_in` held high for 10 cycles → exactly one start.
  - reg_start is ignored.
